// File: rtl/fqmul_arbiter.sv
// Round-robin share of one fqmul among NREQ requesters (define FQMUL_ARB_FIXED_PRIO_EN for fixed priority).
// Accept-to-rsp_valid latency MUL_LAT+2; no response backpressure; flush blocks grants and drains in-flight ops.
module fqmul_arbiter #(
   parameter int NREQ    = 2,
   parameter int MUL_LAT = 2,
   localparam int TAG_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [16*NREQ-1:0]   req_a,
   input  logic [16*NREQ-1:0]   req_b,
   output logic [NREQ-1:0]      req_ready,
   output logic [NREQ-1:0]      rsp_valid,
   output logic signed [15:0]   rsp_t,
   output logic                 mul_set,
   output logic signed [15:0]   mul_a,
   output logic signed [15:0]   mul_b,
   input  logic signed [15:0]   mul_t,
   input  logic                 flush,
   output logic                 flush_done,
   output logic                 busy
);

   typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

   typedef struct packed {
      logic             vld;
      logic [TAG_W-1:0] tag;
   } tag_t;

   state_t           state, state_nxt;
   tag_t             pipe [0:MUL_LAT];
   logic [TAG_W-1:0] iss_tag;
   logic [TAG_W-1:0] gnt_idx;
   logic             accept;
   logic             allow;
   logic             busy_nxt;
   logic             fd_nxt;
`ifndef FQMUL_ARB_FIXED_PRIO_EN
   logic [TAG_W-1:0] ptr;
`endif

   always_comb begin
      req_ready = '0;
      gnt_idx   = '0;
      allow     = (state != DRAIN) && !flush;
`ifdef FQMUL_ARB_FIXED_PRIO_EN
      // scan downwards so the lowest valid index is the one left standing
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req_valid[i]) gnt_idx = TAG_W'(i);
      end
`else
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req_valid[(int'(ptr) + k) % NREQ]) gnt_idx = TAG_W'((int'(ptr) + k) % NREQ);
      end
`endif
      accept = allow && (|req_valid);
      if (accept) req_ready[gnt_idx] = 1'b1;
   end

   // busy_nxt is what busy will read after the coming edge; the FSM leaves ACTIVE on its fall
   always_comb begin
      busy     = mul_set;
      busy_nxt = accept | mul_set;
      for (int i = 0; i <= MUL_LAT; i++) begin
         busy = busy | pipe[i].vld;
         if (i < MUL_LAT) busy_nxt = busy_nxt | pipe[i].vld;
      end
   end

   always_comb begin
      state_nxt = state;
      fd_nxt    = 1'b0;
      case (state)
         IDLE: begin
            if (accept) state_nxt = ACTIVE;
            else if (flush && !flush_done) fd_nxt = 1'b1;
         end
         ACTIVE: begin
            if (flush) state_nxt = DRAIN;
            else if (!busy_nxt) state_nxt = IDLE;
         end
         DRAIN: begin
            if (!busy) begin
               fd_nxt    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         mul_set    <= 1'b0;
         mul_a      <= '0;
         mul_b      <= '0;
         iss_tag    <= '0;
         rsp_valid  <= '0;
         rsp_t      <= '0;
         flush_done <= 1'b0;
         for (int i = 0; i <= MUL_LAT; i++) pipe[i] <= '0;
`ifndef FQMUL_ARB_FIXED_PRIO_EN
         ptr        <= '0;
`endif
      end else begin
         state      <= state_nxt;
         flush_done <= fd_nxt;
         mul_set    <= accept;
         if (accept) begin
            mul_a   <= req_a[16*int'(gnt_idx) +: 16];
            mul_b   <= req_b[16*int'(gnt_idx) +: 16];
            iss_tag <= gnt_idx;
`ifndef FQMUL_ARB_FIXED_PRIO_EN
            ptr     <= (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
`endif
         end
         // tag rides alongside the fqmul pipe, entering as the multiplier samples its operands
         pipe[0].vld <= mul_set;
         pipe[0].tag <= iss_tag;
         for (int i = 1; i <= MUL_LAT; i++) pipe[i] <= pipe[i-1];
         rsp_valid <= '0;
         if (pipe[MUL_LAT].vld) begin
            rsp_valid[pipe[MUL_LAT].tag] <= 1'b1;
            rsp_t                        <= mul_t;
         end
      end
   end

endmodule

// File: tb/tb_fqmul_arbiter.sv
// Bench for fqmul_arbiter: behavioural fqmul plus a queue-based scoreboard of in-flight ops,
// directed scenarios followed by a randomized stress run.
module tb_fqmul_arbiter;
   localparam int NREQ    = 2;
   localparam int MUL_LAT = 2;
   localparam int Q       = 3329;

   logic                clk = 1'b0;
   logic                reset;
   logic [NREQ-1:0]     req_valid, req_ready, rsp_valid;
   logic [16*NREQ-1:0]  req_a, req_b;
   logic signed [15:0]  rsp_t, mul_a, mul_b, mul_t;
   logic                mul_set, flush, flush_done, busy;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fqmul_arbiter #(.NREQ(NREQ), .MUL_LAT(MUL_LAT)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_t(rsp_t), .mul_set(mul_set),
      .mul_a(mul_a), .mul_b(mul_b), .mul_t(mul_t), .flush(flush),
      .flush_done(flush_done), .busy(busy)
   );

   // a*b*2^-16 mod q, returned in [0,q) or shifted into (-q,0) for odd a
   function automatic int fq_res(logic signed [15:0] a, logic signed [15:0] b);
      int m, r;
      m = (int'(a) * int'(b)) % Q;
      if (m < 0) m += Q;
      r = (m * 169) % Q;
      if (a[0] && r != 0) r -= Q;
      return r;
   endfunction

   function automatic int modq(int x);
      return ((x % Q) + Q) % Q;
   endfunction

   // behavioural fqmul: result valid MUL_LAT edges after the edge that sees mul_set
   logic               dv   [0:MUL_LAT-1];
   logic signed [15:0] dval [0:MUL_LAT-1];
   always @(posedge clk) begin
      dv[0]   <= mul_set;
      dval[0] <= 16'(fq_res(mul_a, mul_b));
      for (int i = 1; i < MUL_LAT; i++) begin
         dv[i]   <= dv[i-1];
         dval[i] <= dval[i-1];
      end
      mul_t <= (dv[MUL_LAT-1] === 1'b1) ? dval[MUL_LAT-1] : 16'($urandom);
   end

   typedef struct {
      int tag;
      int due;
      int val;
   } op_t;

   op_t                ops[$];
   int                 cyc, ptr, issued;
   bit                 draining;
   logic               exp_fd, exp_ms;
   logic signed [15:0] exp_ma, exp_mb, last_rt;
   int                 obs_rsp, obs_fd, obs_gnt, obs_rt, last_rsp_cyc;
   logic               last_fd;
   logic [NREQ-1:0]    last_rdy;
   int                 rt_by [NREQ];

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(logic [NREQ-1:0] v, int p);
`ifdef FQMUL_ARB_FIXED_PRIO_EN
      for (int i = 0; i < NREQ; i++) if (v[i]) return i;
`else
      for (int k = 0; k < NREQ; k++) if (v[(p + k) % NREQ]) return (p + k) % NREQ;
`endif
      return -1;
   endfunction

   task automatic model_clear();
      ops.delete();
      ptr = 0; draining = 0; exp_fd = 0; exp_ms = 0;
      exp_ma = '0; exp_mb = '0; last_rt = '0;
   endtask

   // inputs are driven at the negedge before calling; checks run 1 time unit later
   task automatic tick();
      logic [NREQ-1:0] exp_rv, exp_rdy;
      int g, inflight;
      #1;
      exp_rv = '0;
      foreach (ops[i]) if (ops[i].due == cyc) begin
         exp_rv[ops[i].tag] = 1'b1;
         last_rt = 16'(ops[i].val);
      end
      chk("rsp_valid", rsp_valid, exp_rv);
      chk("rsp_t", rsp_t, last_rt);
      if (rsp_valid != '0) begin
         obs_rsp++; last_rsp_cyc = cyc; obs_rt = rsp_t;
      end
      for (int i = 0; i < NREQ; i++) if (rsp_valid[i]) rt_by[i] = rsp_t;
      last_fd = flush_done;
      if (flush_done) obs_fd++;
      for (int i = ops.size() - 1; i >= 0; i--) if (ops[i].due <= cyc) ops.delete(i);
      inflight = ops.size();
      chk("busy", busy, inflight != 0);
      chk("flush_done", flush_done, exp_fd);
      chk("mul_set", mul_set, exp_ms);
      chk("mul_a", mul_a, exp_ma);
      chk("mul_b", mul_b, exp_mb);
      g = (draining || flush) ? -1 : pick(req_valid, ptr);
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", req_ready, exp_rdy);
      last_rdy = req_ready;
      obs_gnt = -1;
      for (int i = 0; i < NREQ; i++) if (req_ready[i] && req_valid[i]) obs_gnt = i;
      exp_ms = (g >= 0);
      if (g >= 0) begin
         exp_ma = req_a[16*g +: 16];
         exp_mb = req_b[16*g +: 16];
         ops.push_back('{tag: g, due: cyc + 1 + MUL_LAT + 2, val: fq_res(exp_ma, exp_mb)});
         ptr = (g + 1) % NREQ;
         issued++;
      end
      if (draining) begin
         exp_fd = (inflight == 0);
         if (inflight == 0) draining = 0;
      end else if (flush && !exp_fd) begin
         exp_fd = (inflight == 0);
         if (inflight != 0) draining = 1;
      end else begin
         exp_fd = 1'b0;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1; req_valid = '0; flush = 1'b0;
      #1;
      chk("rst_req_ready", req_ready, '0);
      chk("rst_rsp_valid", rsp_valid, '0);
      chk("rst_rsp_t", rsp_t, '0);
      chk("rst_mul_set", mul_set, '0);
      chk("rst_mul_a", mul_a, '0);
      chk("rst_mul_b", mul_b, '0);
      chk("rst_flush_done", flush_done, '0);
      chk("rst_busy", busy, '0);
      model_clear();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic idle(int n);
      req_valid = '0; flush = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      int kedge, base;
      int gseq [6];
      reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0; flush = 1'b0;
      cyc = 0; issued = 0; obs_rsp = 0; obs_fd = 0; last_rsp_cyc = -1; obs_rt = 0;
      model_clear();
      @(posedge clk);
      @(negedge clk);
      do_reset();

      // single op with b = R mod q gives back a
      req_a[15:0] = 16'd17; req_b[15:0] = 16'd2285; req_valid = 2'b01;
      kedge = cyc + 1;
      tick();
      idle(7);
      chk("single_latency", last_rsp_cyc - kedge, MUL_LAT + 2);
      chk("single_value", modq(obs_rt), 17);
      chk("single_busy_after", busy, 1'b0);

      do_reset();
      req_a = {16'(-5), 16'd1000}; req_b = {16'd2285, 16'd2285};
`ifdef FQMUL_ARB_FIXED_PRIO_EN
      req_valid = 2'b11;
      for (int i = 0; i < 5; i++) begin
         tick();
         gseq[i] = obs_gnt;
      end
      for (int i = 0; i < 5; i++) chk("fixed_grant", gseq[i], 0);
      req_valid = 2'b10;
      tick();
      chk("fixed_grant_req1", obs_gnt, 1);
      idle(6);
`else
      req_valid = 2'b11;
      for (int i = 0; i < 4; i++) begin
         tick();
         gseq[i] = obs_gnt;
      end
      for (int i = 0; i < 4; i++) chk("rr_grant", gseq[i], i % 2);
      idle(6);
      chk("rr_value_req0", modq(rt_by[0]), 1000);
      chk("rr_value_req1", modq(rt_by[1]), 3324);
`endif

      // flush with three ops in flight
      obs_rsp = 0; obs_fd = 0;
      req_valid = 2'b01;
      for (int i = 0; i < 3; i++) begin
         req_a[15:0] = 16'($urandom); req_b[15:0] = 16'($urandom);
         tick();
      end
      flush = 1'b1;
      tick();
      chk("flush_ready", last_rdy, '0);
      idle(8);
      chk("flush_rsp_count", obs_rsp, 3);
      chk("flush_done_count", obs_fd, 1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      tick();
      chk("idle_flush_done", last_fd, 1'b1);
      idle(2);

      // reset two cycles after an accept discards the op and the pointer
      req_valid = 2'b01; req_a[15:0] = 16'd321; req_b[15:0] = 16'd77;
      tick();
      idle(2);
      do_reset();
      obs_rsp = 0;
      idle(6);
      chk("reset_no_rsp", obs_rsp, 0);
      req_valid = 2'b11;
      tick();
      chk("reset_grant_req0", obs_gnt, 0);
      idle(6);

      // random stress
      base = issued; obs_rsp = 0;
      for (int n = 0; n < 20000 && issued - base < 1000; n++) begin
         req_valid = NREQ'($urandom);
         for (int i = 0; i < NREQ; i++) begin
            req_a[16*i +: 16] = 16'($urandom);
            req_b[16*i +: 16] = 16'($urandom);
         end
         flush = ($urandom_range(0, 39) == 0);
         tick();
      end
      chk("stress_ops_issued", (issued - base) >= 1000, 1'b1);
      idle(MUL_LAT + 4);
      chk("stress_drained", ops.size(), 0);
      chk("stress_strobe_count", obs_rsp, issued - base);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fqmul_arbiter.md
Name: fqmul_arbiter

Overview:
- Shares one pipelined fqmul unit (a*b*R^-1 mod q, q=3329, R=2^16) between NREQ requesters, e.g. NTT butterfly and basemul engines.
- Grants at most one operand pair per cycle and drives the fqmul operand and set inputs.
- Carries a tag alongside each operation so its result is returned only to the requester that issued it.
- Includes a flush state machine so a sequencer can drain all in-flight operations before reconfiguring.

Parameters:
- NREQ, 2, number of requesters (2..8).
- MUL_LAT, 2, cycles from mul_set high at a clk edge to valid mul_t; matches the multiplier + montgomery_reduce pipeline.
- TAG_W, $clog2(NREQ) (minimum 1), derived requester-index width; not for override.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_a  in  16*NREQ  signed operand a; slice i = [16i+15:16i].
- req_b  in  16*NREQ  signed operand b; same slicing as req_a.
- req_ready  out  NREQ  one-hot accept; combinational from req_valid, pointer and state.
- rsp_valid  out  NREQ  one-hot result strobe, registered.
- rsp_t  out  16  signed result, shared by all requesters; qualified by rsp_valid.
- mul_set  out  1  registered enable to fqmul.
- mul_a  out  16  registered operand a to fqmul.
- mul_b  out  16  registered operand b to fqmul.
- mul_t  in  16  fqmul result.
- flush  in  1  level request: stop accepting and drain.
- flush_done  out  1  one-cycle pulse when the drain completes.
- busy  out  1  high while any operation is in flight.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_t=0, mul_set=0, mul_a=0, mul_b=0, flush_done=0, busy=0; RR pointer=0; tag pipe empty; state=IDLE.
- Reset mid-operation discards all in-flight results; no rsp_valid is produced for them.
- Acceptance: requester i is accepted at an edge where req_valid[i]=1 and req_ready[i]=1.
- At most one req_ready bit is high per cycle.
- req_ready is all-zero while state=DRAIN or flush=1.
- On accept at edge k:
  - mul_a/mul_b take the granted operands; mul_set=1 for exactly the cycle after k.
  - {valid=1, tag=i} enters tag pipe stage 0.
- With no accept, mul_set=0 and mul_a/mul_b hold their last values.
- Tag pipe: MUL_LAT+1 stages, advancing every cycle (no stall, no response backpressure). Requesters must take results on the strobe.
- Output: when the last tag stage is valid, rsp_valid[tag]=1 and rsp_t=mul_t, registered.
  - rsp_valid rises MUL_LAT+2 edges after the accept edge; default 4.
  - rsp_t holds its value while rsp_valid=0.
- Throughput: one op per cycle sustained, with back-to-back grants allowed.
- Arbitration: round-robin.
  - Search starts at the pointer index and wraps from NREQ-1 to 0.
  - After a grant to i, the pointer becomes (i+1) mod NREQ; the pointer is unchanged when there is no grant.
- busy = any tag stage valid or mul_set.
- FSM:
  - IDLE: no ops in flight. An accept moves to ACTIVE. flush=1 pulses flush_done next cycle and stays in IDLE.
  - ACTIVE: accepts. flush=1 moves to DRAIN; no accept occurs in that cycle. busy falling with no new accept returns to IDLE.
  - DRAIN: no accepts; in-flight results still delivered. When the pipe is empty, pulse flush_done for 1 cycle and go to IDLE.
  - flush is ignored while flush_done is high.
- Simultaneous: flush=1 in the same cycle as req_valid means no grant. Results returning during a flush are delivered normally.
- Arithmetic is entirely in fqmul; operands pass through unmodified.
- rsp_t is in (-q, q) and congruent to a*b*2^-16 mod 3329.

Optional Feature:
- FQMUL_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; the RR pointer is removed.
- Undefined: round-robin as above.
- Latency, FSM and flush behaviour are identical in both builds.

Test Plan:
- Single op: req0 a=17, b=2285 (R mod q), accept at edge k -> rsp_valid=01 at edge k+4, rsp_t ≡ 17 mod 3329, busy low after.
- Both requesters valid continuously with round-robin: req0 a=1000, b=2285; req1 a=-5, b=2285 -> grants alternate 0,1,0,1; each rsp_valid bit returns its own value (≡1000, ≡3324 mod 3329) in issue order.
- With FQMUL_ARB_FIXED_PRIO_EN, both requesters valid for 5 cycles -> req0 granted all 5, req1 none. When req0 drops, req1 is granted the next cycle.
- Flush with 3 ops in flight -> req_ready=0 from that cycle, 3 rsp_valid pulses, then flush_done pulses exactly once and the state returns to IDLE. A flush in IDLE -> flush_done the next cycle.
- Reset asserted 2 cycles after an accept -> all outputs return to 0 immediately. No rsp_valid afterwards; the next accept is granted to req0.
- Random stress: 1000 ops, random valid/flush, compared against a behavioural fqmul model -> every result routed to its issuing requester, congruent mod 3329, with no lost or duplicated strobes.
